// File: rtl/seq_alu_if.sv
// Request/response bundle for the sequential ALU: the master issues operations
// and consumes results, the slave is the ALU itself.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
           flag_zero, flag_carry, flag_ovf, flag_err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
           flag_zero, flag_carry, flag_ovf, flag_err
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle unsigned
// shift-add multiplier behind a valid/ready request and result handshake.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SLT  = 3'b100,
    OP_NOR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  flags_t               flags_q, flags_d;

  op_e                  op_sel;
  logic [WIDTH:0]       add_ext;
  logic [WIDTH:0]       sub_ext;
  logic [WIDTH-1:0]     alu_res;
  flags_t               alu_flags;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign op_sel  = op_e'(bus.op);
  assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_ext = {1'b0, bus.a} - {1'b0, bus.b};

  // Single-cycle datapath, evaluated on the live operands at accept time.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op_sel)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res         = add_ext[WIDTH-1:0];
        alu_flags.carry = add_ext[WIDTH];
        alu_flags.ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res         = sub_ext[WIDTH-1:0];
        alu_flags.carry = sub_ext[WIDTH];
        alu_flags.ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_MUL: alu_res = '0;
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0) && (op_sel != OP_RSVD);
  end

  // One multiplier bit per cycle: add the multiplicand into the high half when
  // the current LSB is set, then shift the whole product right by one.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (op_sel == OP_MUL) begin
            mcand_d = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = alu_flags;
            state_d     = S_DONE;
          end
        end
      end
      S_BUSY: begin
        prod_d = mul_next;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d         = '0;
          result_d      = mul_next[WIDTH-1:0];
          result_hi_d   = mul_next[2*WIDTH-1:WIDTH];
          flags_d       = '0;
          flags_d.zero  = (mul_next == '0);
          flags_d.carry = (mul_next[2*WIDTH-1:WIDTH] != '0);
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.result     = result_q;
  assign bus.result_hi  = result_hi_q;
  assign bus.flag_zero  = flags_q.zero;
  assign bus.flag_carry = flags_q.carry;
  assign bus.flag_ovf   = flags_q.ovf;
  assign bus.flag_err   = flags_q.err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a vector table of ops with hand-computed results,
// plus back-pressure and mid-multiply reset sequences.
module tb_seq_alu;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flg;   // {zero, carry, ovf, err}
    int           lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err};
  endfunction

  // Issue one op from IDLE (called #1 after an edge). After accept the inputs
  // are scrambled and in_valid kept high until the result shows up.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit ready_seen);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.op     = 3'b010;
    bus.a      = ~a;
    bus.b      = $urandom;
    lat        = 1;
    ready_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  rdy;
    bit  ov_seen;

    vecs[0]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 4'b1100, 1};
    vecs[1]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 4'b0010, 1};
    vecs[2]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0, 4'b1110, 1};
    vecs[3]  = '{3'b011, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0, 4'b0100, 1};
    vecs[4]  = '{3'b011, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 4'b0010, 1};
    vecs[5]  = '{3'b011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 4'b1000, 1};
    vecs[6]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0, 4'b0000, 1};
    vecs[7]  = '{3'b100, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 4'b1000, 1};
    vecs[8]  = '{3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 4'b0000, 1};
    vecs[9]  = '{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0, 4'b0000, 1};
    vecs[10] = '{3'b101, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 4'b0000, 1};
    vecs[11] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0, 4'b1000, 1};
    vecs[12] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h1, 4'b0100, 33};
    vecs[13] = '{3'b110, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 4'b0100, 33};
    vecs[14] = '{3'b110, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0000, 33};
    vecs[15] = '{3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0100, 33};
    vecs[16] = '{3'b110, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0, 4'b1000, 33};
    vecs[17] = '{3'b111, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'h0, 4'b0001, 1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #22;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result",    bus.result,    32'h0);
    check("rst_result_hi", bus.result_hi, 32'h0);
    check("rst_flags",     flags_now(),   4'b0000);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy);
      check($sformatf("v%0d_latency", i),   lat,           vecs[i].lat);
      check($sformatf("v%0d_result", i),    bus.result,    vecs[i].res);
      check($sformatf("v%0d_result_hi", i), bus.result_hi, vecs[i].hi);
      check($sformatf("v%0d_flags", i),     flags_now(),   vecs[i].flg);
      check($sformatf("v%0d_busy_ready", i), rdy,          1'b0);
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after", i), {bus.in_ready, bus.out_valid}, 2'b10);
    end

    // Back-pressure: NOR 0,0 held in DONE for 5 cycles with a stray request.
    bus.out_ready = 1'b0;
    bus.op = 3'b101; bus.a = '0; bus.b = '0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_valid", c), bus.out_valid, 1'b1);
      check($sformatf("bp%0d_result", c),    bus.result,    32'hFFFF_FFFF);
      check($sformatf("bp%0d_in_ready", c),  bus.in_ready,  1'b0);
      bus.in_valid = (c == 2);
      bus.op = 3'b010; bus.a = 32'h1; bus.b = 32'h1;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    check("bp_result_kept", bus.result, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("bp_no_late_accept", bus.out_valid, 1'b0);

    // Reset asserted between edges in the middle of a multiply.
    bus.op = 3'b110; bus.a = 32'hFFFF_FFFF; bus.b = 32'h2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("mid_mul_busy", bus.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready",  bus.in_ready,  1'b1);
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    #10 rst_n = 1'b1;
    #1;
    check("post_rst_result",    bus.result,    32'h0);
    check("post_rst_result_hi", bus.result_hi, 32'h0);
    check("post_rst_flags",     flags_now(),   4'b0000);
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ov_seen = 1'b1;
    end
    check("post_rst_quiet", ov_seen, 1'b0);
    run_op(3'b111, 32'hDEAD_BEEF, 32'h1234_5678, lat, rdy);
    check("post_rst_err_latency", lat,         1);
    check("post_rst_err_flags",   flags_now(), 4'b0001);
    check("post_rst_err_result",  {bus.result_hi, bus.result}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
